boot_loader: RTL and testbench



---
 rtl/boot_loader.sv | 149 ++++++++++++++
 tb/tb_boot_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Instruction-memory boot loader: assembles a little-endian byte stream into words,
// writes them from address 0 and then releases the core. Optional trailing XOR
// checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module boot_loader #(
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_run,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
`ifdef BOOT_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   state_t            state;
   logic [7:0]        len_lo;
   logic [15:0]       n_words;
   logic [1:0]        byte_cnt;
   logic [ADDR_W:0]   word_cnt;
   logic [23:0]       asm_q;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        chk_q;
`endif

   logic              accept;
   logic [15:0]       len_n;
   logic [ADDR_W:0]   word_nxt;
   logic              last_word;

   // Ready decodes only the state register, never rx_valid.
   always_comb begin
      rx_ready = 1'b0;
      case (state)
         S_LEN0, S_LEN1, S_DATA: rx_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         S_CHK:                  rx_ready = 1'b1;
`endif
         default:                rx_ready = 1'b0;
      endcase
   end

   assign busy      = rx_ready;
   assign accept    = rx_valid && rx_ready;
   assign len_n     = {rx_data, len_lo};
   assign word_nxt  = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
   assign last_word = (32'(word_nxt) == 32'(n_words));

   // NOTE: all state and outputs use non-blocking assignments so every register
   // sees pre-edge values; the reset branch clears them synchronously.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LEN0;
         len_lo    <= '0;
         n_words   <= '0;
         byte_cnt  <= '0;
         word_cnt  <= '0;
         asm_q     <= '0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         core_run  <= 1'b0;
         err       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         chk_q     <= '0;
`endif
      end else begin
         mem_wr <= 1'b0;
         if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            if (state != S_CHK) chk_q <= chk_q ^ rx_data;
`endif
            case (state)
               S_LEN0: begin
                  len_lo <= rx_data;
                  state  <= S_LEN1;
               end
               S_LEN1: begin
                  n_words <= len_n;
                  if (len_n == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                     state    <= S_CHK;
`else
                     state    <= S_DONE;
                     core_run <= 1'b1;
`endif
                  end else if ({1'b0, len_n} > MAX_W) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     mem_wr    <= 1'b1;
                     mem_addr  <= word_cnt[ADDR_W-1:0];
                     mem_wdata <= {rx_data, asm_q};
                     word_cnt  <= word_nxt;
                     if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                        state    <= S_CHK;
`else
                        state    <= S_DONE;
                        core_run <= 1'b1;
`endif
                     end
                  end else begin
                     // Earlier bytes shift down so the first lands in [7:0].
                     asm_q <= {rx_data, asm_q[23:8]};
                  end
               end
`ifdef BOOT_CHECKSUM_EN
               S_CHK: begin
                  if (rx_data == chk_q) begin
                     state    <= S_DONE;
                     core_run <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table-driven streams plus hand-written
// sequences for reset mid-load, the MAX_WORDS boundary and checksum mismatch.
module tb_boot_loader;

   localparam int ADDR_W = 12;
`ifdef BOOT_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        rx_data = '0;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_run;
   logic              busy;
   logic              err;

   boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(4096)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_run  (core_run),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Write log captured on the falling edge.
   int                wr_total = 0;
   logic [ADDR_W-1:0] wr_addr [64];
   logic [31:0]       wr_data [64];
   bit                prev_wr = 1'b0;
   bit                dbl_strobe = 1'b0;

   always @(negedge clk) begin
      if (mem_wr) begin
         if (wr_total < 64) begin
            wr_addr[wr_total] = mem_addr;
            wr_data[wr_total] = mem_wdata;
         end
         wr_total++;
         if (prev_wr) dbl_strobe = 1'b1;
      end
      prev_wr = mem_wr;
   end

   typedef struct {
      int           nbytes;
      logic [127:0] bytes;    // byte 0 is the most significant of the nbytes used
      int           nwr;
      logic [31:0]  d [4];
      bit           run;
      bit           er;
      bit           add_chk;
      bit           gappy;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " rx_ready"},  32'(rx_ready),  32'd1);
      check({tag, " mem_wr"},    32'(mem_wr),    32'd0);
      check({tag, " mem_addr"},  32'(mem_addr),  32'd0);
      check({tag, " mem_wdata"}, mem_wdata,      32'd0);
      check({tag, " core_run"},  32'(core_run),  32'd0);
      check({tag, " busy"},      32'(busy),      32'd1);
      check({tag, " err"},       32'(err),       32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      rx_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
   endtask

   // Called on a falling edge; returns on the falling edge after the accepting rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
      acc = 1'b0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (rx_ready) begin
            @(posedge clk);
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (acc) @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_list(input logic [63:0] bl, input int n, input string tag);
      bit acc;
      for (int i = 0; i < n; i++) begin
         send_byte(bl[(n-1-i)*8 +: 8], 0, acc);
         check({tag, " accept"}, 32'(acc), 32'd1);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          base;
      logic [7:0]  x;
      logic [7:0]  bt;
      bit          acc;
      bit          chk_sent;
      string       tag;
      tag = $sformatf("vec%0d", idx);
      do_reset();
      base = wr_total;
      x = '0;
      chk_sent = v.add_chk && CHK_ON;
      for (int i = 0; i < v.nbytes; i++) begin
         bt = v.bytes[(v.nbytes-1-i)*8 +: 8];
         x ^= bt;
         send_byte(bt, v.gappy ? int'($urandom_range(0, 3)) : 0, acc);
         check({tag, " accept"}, 32'(acc), 32'd1);
      end
      if (chk_sent) begin
         send_byte(x, 0, acc);
         check({tag, " chk accept"}, 32'(acc), 32'd1);
      end
      // One cycle after the final byte.
      check({tag, " core_run"}, 32'(core_run), 32'(v.run));
      check({tag, " err"},      32'(err),      32'(v.er));
      check({tag, " busy"},     32'(busy),     32'd0);
      check({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, " last strobe"}, 32'(mem_wr), 32'(v.nwr > 0 && !chk_sent));
      send_byte(8'hff, 0, acc);
      check({tag, " no accept after end"}, 32'(acc), 32'd0);
      repeat (2) @(negedge clk);
      check({tag, " core_run held"}, 32'(core_run), 32'(v.run));
      check({tag, " write count"}, 32'(wr_total - base), 32'(v.nwr));
      for (int i = 0; i < v.nwr && i < 4; i++) begin
         check($sformatf("%s addr%0d", tag, i), 32'(wr_addr[base+i]), 32'(i));
         check($sformatf("%s data%0d", tag, i), wr_data[base+i], v.d[i]);
      end
   endtask

   initial begin
      int  base;
      bit  acc;

      vecs[0].nbytes = 6;  vecs[0].bytes = 128'h01_00_13_05_50_00;
      vecs[0].nwr = 1;     vecs[0].d[0] = 32'h0050_0513;
      vecs[0].run = 1;     vecs[0].er = 0; vecs[0].add_chk = 1; vecs[0].gappy = 0;

      vecs[1].nbytes = 2;  vecs[1].bytes = 128'h00_00;
      vecs[1].nwr = 0;
      vecs[1].run = 1;     vecs[1].er = 0; vecs[1].add_chk = 1; vecs[1].gappy = 0;

      vecs[2].nbytes = 14; vecs[2].bytes = 128'h03_00_11_22_33_44_55_66_77_88_99_aa_bb_cc;
      vecs[2].nwr = 3;
      vecs[2].d[0] = 32'h4433_2211; vecs[2].d[1] = 32'h8877_6655; vecs[2].d[2] = 32'hccbb_aa99;
      vecs[2].run = 1;     vecs[2].er = 0; vecs[2].add_chk = 1; vecs[2].gappy = 1;

      vecs[3].nbytes = 2;  vecs[3].bytes = 128'h01_10;
      vecs[3].nwr = 0;
      vecs[3].run = 0;     vecs[3].er = 1; vecs[3].add_chk = 0; vecs[3].gappy = 0;

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // N = 4096 is exactly the limit and must be accepted as a load.
      do_reset();
      send_list(64'h00_10, 2, "max");
      check("max err",      32'(err),      32'd0);
      check("max busy",     32'(busy),     32'd1);
      check("max rx_ready", 32'(rx_ready), 32'd1);

      // Reset in the middle of a two-word load, then a fresh one-word load.
      do_reset();
      base = wr_total;
      send_list(64'h02_00_11_22_33_44_55, 7, "midload");
      check("midload first write", 32'(wr_total - base), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("midload");
      reset = 1'b0;
      base = wr_total;
      send_list(64'h01_00_de_ad_be_ef, 6, "reload");
      if (CHK_ON) begin
         send_byte(8'h01 ^ 8'hde ^ 8'had ^ 8'hbe ^ 8'hef, 0, acc);
         check("reload chk accept", 32'(acc), 32'd1);
      end
      repeat (2) @(negedge clk);
      check("reload core_run", 32'(core_run), 32'd1);
      check("reload writes",   32'(wr_total - base), 32'd1);
      check("reload addr",     32'(wr_addr[base]), 32'd0);
      check("reload data",     wr_data[base], 32'hefbe_adde);

      if (CHK_ON) begin
         do_reset();
         send_list(64'h01_00_13_05_50_00_47, 7, "chk good");
         check("chk good core_run", 32'(core_run), 32'd1);
         check("chk good err",      32'(err),      32'd0);
         do_reset();
         send_list(64'h01_00_13_05_50_00_00, 7, "chk bad");
         check("chk bad err",      32'(err),      32'd1);
         check("chk bad core_run", 32'(core_run), 32'd0);
         check("chk bad rx_ready", 32'(rx_ready), 32'd0);
      end

      check("no overlapping strobes", 32'(dbl_strobe), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
